// File: rtl/run_len_detect.sv
// run_len_detect -- flags a run of RUN_LEN or more equal enabled samples on a
// serial input. Polarity is selectable, and a one-cycle rise pulse marks each
// qualifying run. A saturating counter tallies the rise events.
//
// Ports
//   clk_i      clock, all state on posedge
//   reset_i    synchronous active-high reset (priority over en_i / clr_i)
//   en_i       sample enable; in_i is only looked at when en_i=1
//   in_i       serial input bit
//   mode_i     polarity enable: [0] ones, [1] zeros (00 none, 11 both)
//   clr_i      synchronous clear of evt_cnt_o only
//   out_o      run >= RUN_LEN of an enabled polarity in progress (comb)
//   rise_o     registered pulse, enabled run has just reached RUN_LEN
//   run_val_o  value of the current run
//   run_cnt_o  current run length, saturating at RUN_LEN
//   evt_cnt_o  number of rise events, saturating at all-ones
module run_len_detect #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           en_i,
  input  logic                           in_i,
  input  logic [1:0]                     mode_i,
  input  logic                           clr_i,
  output logic                           out_o,
  output logic                           rise_o,
  output logic                           run_val_o,
  output logic [$clog2(RUN_LEN+1)-1:0]   run_cnt_o,
  output logic [CNT_W-1:0]               evt_cnt_o
);

  localparam int RC_W = $clog2(RUN_LEN+1);
  localparam logic [RC_W-1:0] RL  = RC_W'(RUN_LEN);
  localparam logic [RC_W-1:0] ONE = RC_W'(1);

  typedef enum logic [1:0] {EMPTY = 2'd0, COUNT = 2'd1, HIT = 2'd2} state_e;

  // A fresh run of length 1 is already a hit when RUN_LEN is 1.
  localparam state_e START_ST = (RUN_LEN == 1) ? HIT : COUNT;

  state_e            state_q, state_d;
  logic              cur_q, cur_d;
  logic [RC_W-1:0]   run_cnt_q, run_cnt_d;
  logic              rise_q, rise_d;
  logic [CNT_W-1:0]  evt_cnt_q, evt_cnt_d;
  logic              evt;

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    run_cnt_d = run_cnt_q;
    if (en_i) begin
      unique case (state_q)
        EMPTY: begin
          cur_d     = in_i;
          run_cnt_d = ONE;
          state_d   = START_ST;
        end
        COUNT: begin
          if (in_i != cur_q) begin
            cur_d     = in_i;
            run_cnt_d = ONE;
            state_d   = START_ST;
          end else begin
            run_cnt_d = run_cnt_q + ONE;
            if (run_cnt_d == RL) state_d = HIT;
          end
        end
        HIT: begin
          // equal bits keep run_cnt parked at RUN_LEN
          if (in_i != cur_q) begin
            cur_d     = in_i;
            run_cnt_d = ONE;
            state_d   = START_ST;
          end
        end
        default: begin
          state_d   = EMPTY;
          cur_d     = 1'b0;
          run_cnt_d = '0;
        end
      endcase
    end
  end

  // Event: entering HIT, unless we were already in HIT on the same value
  // (a run extending past RUN_LEN), and the new run's polarity is enabled.
  always_comb begin
    evt = en_i && (state_d == HIT)
          && !((state_q == HIT) && (cur_q == cur_d))
          && (cur_d ? mode_i[0] : mode_i[1]);
    rise_d = evt;
  end

  // clr wins over the held count but a coincident event still counts as one.
  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if (clr_i)
      evt_cnt_d = evt ? CNT_W'(1) : '0;
    else if (evt && (evt_cnt_q != {CNT_W{1'b1}}))
      evt_cnt_d = evt_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= EMPTY;
      cur_q     <= 1'b0;
      run_cnt_q <= '0;
      rise_q    <= 1'b0;
      evt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      run_cnt_q <= run_cnt_d;
      rise_q    <= rise_d;
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign out_o     = (state_q == HIT) && (cur_q ? mode_i[0] : mode_i[1]);
  assign rise_o    = rise_q;
  assign run_val_o = cur_q;
  assign run_cnt_o = run_cnt_q;
  assign evt_cnt_o = evt_cnt_q;

endmodule

// File: tb/tb_run_len_detect.sv
// Bench for run_len_detect: two instances (CNT_W=8 and CNT_W=2) share stimulus.
// A run-length model computes expected outputs when stimulus is driven; they are
// queued and compared one cycle later after the clock edge.
module tb_run_len_detect;

  localparam int RUN_LEN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1, en = 1'b0, din = 1'b0, clr = 1'b0;
  logic [1:0] mode = 2'b11;

  logic       out_a, rise_a, val_a;
  logic [2:0] rcnt_a;
  logic [7:0] evt_a;
  logic       out_b, rise_b, val_b;
  logic [2:0] rcnt_b;
  logic [1:0] evt_b;

  run_len_detect #(.RUN_LEN(RUN_LEN), .CNT_W(8)) dut (
    .clk_i(clk), .reset_i(rst), .en_i(en), .in_i(din), .mode_i(mode), .clr_i(clr),
    .out_o(out_a), .rise_o(rise_a), .run_val_o(val_a), .run_cnt_o(rcnt_a),
    .evt_cnt_o(evt_a));

  run_len_detect #(.RUN_LEN(RUN_LEN), .CNT_W(2)) dut2 (
    .clk_i(clk), .reset_i(rst), .en_i(en), .in_i(din), .mode_i(mode), .clr_i(clr),
    .out_o(out_b), .rise_o(rise_b), .run_val_o(val_b), .run_cnt_o(rcnt_b),
    .evt_cnt_o(evt_b));

  always #5 clk = ~clk;

  typedef struct {
    logic       out;
    logic       rise;
    logic       val;
    logic [2:0] rcnt;
    logic [7:0] evt8;
    logic [1:0] evt2;
  } exp_t;

  exp_t sb_q[$];

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model state: unbounded run length (capped at RUN_LEN+1), run value, counters
  int rl = 0, ev8 = 0, ev2 = 0;
  bit mval = 0, mrise = 0;

  function automatic bit pol_en(input bit v, input logic [1:0] m);
    return v ? m[0] : m[1];
  endfunction

  task automatic step(input bit r, input bit e, input bit b, input logic [1:0] m, input bit c);
    exp_t x, y;
    bit evnt;
    @(negedge clk);
    rst = r; en = e; din = b; mode = m; clr = c;
    evnt = 0;
    if (r) begin
      rl = 0; mval = 0; ev8 = 0; ev2 = 0; mrise = 0;
    end else begin
      if (e) begin
        if (rl == 0 || b != mval) begin
          rl = 1; mval = b;
        end else if (rl <= RUN_LEN) rl++;
        evnt = (rl == RUN_LEN) && pol_en(mval, m);
      end
      mrise = evnt;
      if (c) begin
        ev8 = evnt ? 1 : 0; ev2 = evnt ? 1 : 0;
      end else if (evnt) begin
        if (ev8 < 255) ev8++;
        if (ev2 < 3) ev2++;
      end
    end
    x.out  = (rl >= RUN_LEN) && pol_en(mval, m);
    x.rise = mrise;
    x.val  = mval;
    x.rcnt = 3'((rl > RUN_LEN) ? RUN_LEN : rl);
    x.evt8 = 8'(ev8);
    x.evt2 = 2'(ev2);
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      y = sb_q.pop_front();
      chk("out",     out_a,  y.out);
      chk("rise",    rise_a, y.rise);
      chk("run_val", val_a,  y.val);
      chk("run_cnt", rcnt_a, y.rcnt);
      chk("evt_cnt", evt_a,  y.evt8);
      chk("evt2",    evt_b,  y.evt2);
      chk("rise2",   rise_b, y.rise);
    end
  endtask

  // change mode between edges; out must follow without a clock
  task automatic set_mode(input logic [1:0] m);
    mode = m;
    #1;
    chk("out_mode", out_a, (rl >= RUN_LEN) && pol_en(mval, m));
  endtask

  initial begin : main
    logic [1:0] evt2_exp [5];
    bit pb;
    evt2_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // T1: reset, four zeros
    step(1, 0, 0, 2'b11, 0);
    step(1, 0, 0, 2'b11, 0);
    chk("rst_out", out_a, 0);
    chk("rst_cnt", rcnt_a, 0);
    chk("rst_evt", evt_a, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 2'b11, 0);
    chk("t1_out", out_a, 1);
    chk("t1_rise", rise_a, 1);
    chk("t1_evt", evt_a, 1);

    // T2: broken run of ones then full run
    step(1, 0, 0, 2'b11, 0);
    foreach (evt2_exp[i]) ; // keep table declared once
    step(0, 1, 1, 2'b11, 0); step(0, 1, 1, 2'b11, 0); step(0, 1, 1, 2'b11, 0);
    step(0, 1, 0, 2'b11, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 2'b11, 0);
    chk("t2_rise", rise_a, 1);
    chk("t2_cnt", rcnt_a, 4);

    // T3: long run, single rise, then flip
    step(1, 0, 0, 2'b11, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 1, 2'b11, 0);
    chk("t3_evt", evt_a, 1);
    step(0, 1, 0, 2'b11, 0);
    chk("t3_out", out_a, 0);

    // T4: disabled polarity, then enable it by mode
    step(1, 0, 0, 2'b01, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 2'b01, 0);
    chk("t4_evt", evt_a, 0);
    set_mode(2'b10);
    step(0, 0, 0, 2'b10, 0);

    // T5: en toggling, input wiggles on disabled cycles
    step(1, 0, 0, 2'b11, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 1, 2'b11, 0);
      step(0, 0, 0, 2'b11, 0);
    end

    // T6: five runs saturate the 2-bit counter
    step(1, 0, 0, 2'b11, 0);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) step(0, 1, (k % 2) == 0, 2'b11, 0);
      chk("t6_evt2", evt_b, evt2_exp[k]);
    end
    for (int i = 0; i < 3; i++) step(0, 1, 0, 2'b11, 0);
    step(0, 1, 0, 2'b11, 1);
    chk("t6_clr_evt", evt_a, 1);
    step(0, 1, 0, 2'b11, 1);
    chk("t6_clr0", evt_a, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 2'b11, 0);
    step(1, 1, 1, 2'b11, 0);
    chk("t6_rst_cnt", rcnt_a, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 2'b11, 0);
    chk("t6_norise", rise_a, 0);

    // random soak with run-friendly input
    pb = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) pb = ~pb;
      step($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, pb,
           2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
